prio_grant_dec3_8: RTL

//  Return path of the 8:3 priority encoder. Takes the encoder's winning index
//  (code) and its idle flag, then drives a registered one-hot grant back to the
//  8 requesters. The grant is held until the requester signals done (or a

---
 rtl/prio_grant_dec3_8_pkg.sv | 15 +
 rtl/prio_grant_dec3_8_if.sv | 24 ++
 rtl/prio_grant_dec3_8_bin_dec.sv | 15 +
 rtl/prio_grant_dec3_8.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/prio_grant_dec3_8_pkg.sv
// Shared constants and state encoding for the priority-grant return path.
// Used by every file of prio_grant_dec3_8 (optional feature macro: DEC_TIMEOUT_EN).
package dec_pkg;

    localparam int CODE_W      = 3;
    localparam int N_OUT       = 1 << CODE_W;
    localparam int GAP_CYC_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } dec_state_e;

endpackage

// File: rtl/prio_grant_dec3_8_if.sv
// Bus between the 8:3 encoder/requesters (master) and the grant decoder (slave).
// Part of prio_grant_dec3_8 (optional feature macro: DEC_TIMEOUT_EN).
interface prio_grant_dec3_8_if;
    import dec_pkg::*;

    logic [CODE_W-1:0] code;
    logic              idle;
    logic              done;
    logic [N_OUT-1:0]  grant;
    logic [CODE_W-1:0] grant_code;
    logic              busy;
    logic              timeout;

    modport master (
        output code, idle, done,
        input  grant, grant_code, busy, timeout
    );

    modport slave (
        input  code, idle, done,
        output grant, grant_code, busy, timeout
    );

endinterface

// File: rtl/prio_grant_dec3_8_bin_dec.sv
// Combinational CODE_W -> N_OUT one-hot decoder, the counterpart of bin_enc.
// Part of prio_grant_dec3_8 (optional feature macro: DEC_TIMEOUT_EN).
module bin_dec
    import dec_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [N_OUT-1:0]  onehot
);

    // shift a single set bit into position
    always_comb begin
        onehot = N_OUT'(1) << code;
    end

endmodule

// File: rtl/prio_grant_dec3_8.sv
// Registered one-hot grant driver: IDLE -> GRANT -> GAP, released by done.
// Define DEC_TIMEOUT_EN to add the hold counter and forced release after HOLD_MAX cycles.
module prio_grant_dec3_8
    import dec_pkg::*;
#(
    parameter int GAP_CYC = GAP_CYC_DEF
`ifdef DEC_TIMEOUT_EN
    , parameter int HOLD_MAX = 15
`endif
)
(
    input  logic               clk,
    input  logic               rst_n,
    prio_grant_dec3_8_if.slave bus
);

    localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

`ifdef DEC_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_MAX);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_nxt_s;
    logic              timeout_r;
    logic              timeout_nxt_s;
`endif

    dec_state_e        state_r;
    dec_state_e        state_nxt_s;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [GAP_W-1:0]  gap_nxt_s;
    logic [CODE_W-1:0] grant_code_r;
    logic [CODE_W-1:0] code_nxt_s;
    logic [N_OUT-1:0]  grant_r;
    logic [N_OUT-1:0]  grant_nxt_s;
    logic [N_OUT-1:0]  dec_s;
    logic              busy_r;
    logic              busy_nxt_s;

    bin_dec u_bin_dec (
        .code   (code_nxt_s),
        .onehot (dec_s)
    );

    // next-state, counter and output-register inputs
    always_comb begin
        state_nxt_s = state_r;
        code_nxt_s  = grant_code_r;
        gap_nxt_s   = gap_cnt_r;
`ifdef DEC_TIMEOUT_EN
        hold_nxt_s    = {HOLD_W{1'b0}};
        timeout_nxt_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (!bus.idle) begin
                    state_nxt_s = ST_GRANT;
                    code_nxt_s  = bus.code;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // done takes precedence over a simultaneous timeout hit
                if (bus.done) begin
                    state_nxt_s = ST_GAP;
                    gap_nxt_s   = GAP_LOAD;
`ifdef DEC_TIMEOUT_EN
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s   = ST_GAP;
                    gap_nxt_s     = GAP_LOAD;
                    timeout_nxt_s = 1'b1;
                end else if (hold_cnt_r == HOLD_TOP) begin
                    hold_nxt_s = hold_cnt_r;
                end else begin
                    hold_nxt_s = hold_cnt_r + HOLD_W'(1);
                end
`else
                end else begin
                    state_nxt_s = ST_GRANT;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt_r == {GAP_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_nxt_s = gap_cnt_r - GAP_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (state_nxt_s == ST_GRANT) begin
            grant_nxt_s = dec_s;
        end else begin
            grant_nxt_s = {N_OUT{1'b0}};
        end
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // state, counters and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            gap_cnt_r    <= {GAP_W{1'b0}};
            grant_code_r <= {CODE_W{1'b0}};
            grant_r      <= {N_OUT{1'b0}};
            busy_r       <= 1'b0;
`ifdef DEC_TIMEOUT_EN
            hold_cnt_r   <= {HOLD_W{1'b0}};
            timeout_r    <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            gap_cnt_r    <= gap_nxt_s;
            grant_code_r <= code_nxt_s;
            grant_r      <= grant_nxt_s;
            busy_r       <= busy_nxt_s;
`ifdef DEC_TIMEOUT_EN
            hold_cnt_r   <= hold_nxt_s;
            timeout_r    <= timeout_nxt_s;
`endif
        end
    end

    assign bus.grant      = grant_r;
    assign bus.grant_code = grant_code_r;
    assign bus.busy       = busy_r;
`ifdef DEC_TIMEOUT_EN
    assign bus.timeout    = timeout_r;
`else
    assign bus.timeout    = 1'b0;
`endif

endmodule
